// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the fetch FSM state encoding, the datapath widths, the NOP word
// loaded into the instruction buffer at reset, and the PC increment helper.
package fetch_pkg;

  localparam int XLEN     = 32;
  localparam int OPCODE_W = 7;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10,
    S_HALT = 2'b11
  } fetch_state_t;

  // Sequential PC step; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, holds the
// returned word until decode consumes it, and follows redirects from execute.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr   single-cycle fetch request (combinational in S_REQ)
//   imem_rvalid/rdata    returned word, only honoured in S_WAIT
//   redirect_valid/_target  taken branch/jump and its new PC
//   decode_ready         decode consumes the held instruction
//   instr_valid, instruction, opcode, instr_pc  held instruction buffer
//   fetch_fault          sticky misaligned-redirect flag
//
// Build option: FETCH_MISALIGN_CHK_EN -- when defined, a redirect target with
// nonzero low bits raises fetch_fault and parks the unit in S_HALT until reset.
// When undefined, the low target bits are dropped and fetch_fault stays 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  input  logic                decode_ready,
  output logic                instr_valid,
  output logic [XLEN-1:0]     instruction,
  output logic [OPCODE_W-1:0] opcode,
  output logic [XLEN-1:0]     instr_pc,
  output logic                fetch_fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] tgt_s;
  logic            misalign_s;

`ifdef FETCH_MISALIGN_CHK_EN
  assign tgt_s      = redirect_target;
  assign misalign_s = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
  assign tgt_s      = redirect_target & ~32'h0000_0003;
  assign misalign_s = 1'b0;
`endif

  // A redirect in S_REQ cancels this cycle's request so the stale PC is never fetched.
  assign imem_req    = (state_q == S_REQ) && !reset && !redirect_valid;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign opcode      = instr_q[OPCODE_W-1:0];
  assign instr_pc    = ipc_q;
  assign fetch_fault = fault_q;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    if (misalign_s && (state_q != S_HALT)) begin
      fault_d = 1'b1;
      valid_d = 1'b0;
      kill_d  = 1'b0;
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_REQ: begin
          if (redirect_valid) begin
            pc_d = tgt_s;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_d = tgt_s;
            // If the in-flight word lands this same cycle it is already stale.
            if (imem_rvalid) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              kill_d  = 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              instr_d = imem_rdata;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_step(pc_q);
              state_d = S_HOLD;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          // Redirect wins over a simultaneous decode handshake.
          if (redirect_valid) begin
            valid_d = 1'b0;
            pc_d    = tgt_s;
            state_d = S_REQ;
          end else if (decode_ready) begin
            valid_d = 1'b0;
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

endmodule
